midi_rx: RTL
============

// Module: midi_rx
// PURPOSE
//  MIDI input receiver: the receive-side companion of the core's MIDI TX path.
//  Deserialises 31250 baud 8N1 serial data on the core clock and parses the bytes into MIDI messages.
//  Handles running status, realtime bytes and SysEx.
//  Presents complete messages through a one-entry valid/ready holding register for core register-space polling.
// PARAMETERS
//  CLK_HZ    160_000_000  core clock frequency, Hz
//  BAUD      31250        serial bit rate, bits/s
//  BIT_CLKS  CLK_HZ/BAUD  clocks per bit (derived localparam, counter width = $clog2(BIT_CLKS))
// PORTS
//  clk_i       in   1   core clock
//  rst_i       in   1   async reset, active high
//  midi_rx_i   in   1   async serial input, idle high
//  msg_o       out  24  {status, data1, data2}; unused data bytes = 8'h00
//  msg_len_o   out  2   bytes valid in msg_o: 1..3
//  msg_vld_o   out  1   holding register full
//  msg_rdy_i   in   1   consumer accepts msg_o when msg_vld_o & msg_rdy_i
//  ovr_o       out  1   1-clk pulse: completed message dropped, register full
//  ferr_o      out  1   1-clk pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//  Reset values:
//   - all outputs 0
//   - running status cleared, SysEx flag cleared, RX FSM in IDLE, sync flops = 1
//   - rst_i asserted mid-byte or mid-message abandons it without any pulse.
//  Input synchronisation: 2-flop sync of midi_rx_i; edge detection on the synced signal.
//  RX FSM:
//   - IDLE -> START on synced falling edge.
//   - START: wait BIT_CLKS/2. Line high -> IDLE (glitch, no error). Line low -> DATA.
//   - DATA: sample every BIT_CLKS, 8 bits LSB first -> STOP.
//   - STOP: sample after BIT_CLKS.
//     - 1 -> byte strobe to parser, -> IDLE.
//     - 0 -> ferr_o pulse, byte dropped, -> IDLE. Parser state is unchanged.
//  Parser (one byte per strobe):
//   - F8-FF realtime: emitted at once as a len-1 message. Running status, SysEx flag and partial data untouched.
//   - F0: set SysEx flag, clear running status. Data bytes are discarded until the next non-realtime status byte.
//   - F7: clear SysEx flag and running status; nothing emitted.
//   - 80-EF: load running status, clear SysEx flag and the data index.
//     - Needs 2 data bytes: 8n, 9n, An, Bn, En.
//     - Needs 1 data byte: Cn, Dn.
//   - F1 and F3 need 1 data byte, F2 needs 2; all three clear running status after emission.
//   - F6 is emitted at once as len 1.
//   - F4, F5 are discarded; all of F1-F6 clear running status.
//   - Data byte (bit7=0) with no running status and no SysEx: discarded.
//   - Final data byte: emit a message of len 1+N. Running status is retained for channel messages.
//     The data index resets, so a following data byte pair reuses the status byte.
//  Output handshake:
//   - A message loads the holding register when empty.
//   - It also loads when msg_vld_o & msg_rdy_i in the same clock (simultaneous accept+load: new message wins, vld stays 1).
//   - If full and not accepted: new message dropped, ovr_o pulse, held message unchanged.
//   - msg_vld_o falls the clock after accept when nothing new arrives.
//  Latency: msg_vld_o rises 1 clk after the stop-bit sample of the final byte.
// TESTING
//  1. Send 90 3C 64 at 31250 baud -> msg_o=0x903C64, len=3, vld=1; accept -> vld=0 next clk.
//  2. Send 90 3C 64 3E 00 (running status) -> two messages 0x903C64 then 0x903E00, each len 3.
//  3. Send 90 3C F8 64 -> 0xF80000 len 1 first, then 0x903C64 len 3; running status intact.
//  4. Send F0 7E 01 F7 then 3C -> nothing emitted, no errors.
//     Send C5 07 -> 0xC50700 len 2.
//  5. Hold msg_rdy_i=0; send 90 3C 64 then D0 10 -> first message held; ovr_o pulses once at second completion.
//     Byte with stop bit 0 -> ferr_o pulse, no message.
//     300 ns low glitch -> no byte.
//  6. Assert rst_i mid-data-byte -> all outputs 0.
//     Next full 80 40 00 -> 0x804000 len 3.

Source files
------------

// File: rtl/midi_rx.sv
// midi_rx: 8N1 MIDI receiver with a running-status parser and a one-entry valid/ready message register.
module midi_rx #(
    parameter int CLK_HZ = 160_000_000,
    parameter int BAUD   = 31250
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        midi_rx_i,
    output logic [23:0] msg_o,
    output logic [1:0]  msg_len_o,
    output logic        msg_vld_o,
    input  logic        msg_rdy_i,
    output logic        ovr_o,
    output logic        ferr_o
);
    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] HALF = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;

    logic s1, s2, s3;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic half_tick, full_tick, byte_stb, ferr_n;

    logic [7:0] run_st, run_n, d1, d1_n;
    logic sysex, sysex_n, idx, idx_n, need1;
    logic emit;
    logic [23:0] emit_msg;
    logic [1:0] emit_len;

    assign half_tick = cnt == HALF;
    assign full_tick = cnt == FULL;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
            ferr_o <= 1'b0;
        end else begin
            s1 <= midi_rx_i;
            s2 <= s1;
            s3 <= s2;
            state <= state_n;
            ferr_o <= ferr_n;
            cnt <= (state_n != state || (state == DATA && full_tick)) ? '0 : cnt + CW'(1);
            if (state == DATA && full_tick) begin
                shreg <= {s2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        byte_stb = 1'b0;
        ferr_n = 1'b0;
        case (state)
            IDLE:  state_n = (s3 & ~s2) ? START : IDLE;
            START: state_n = half_tick ? (s2 ? IDLE : DATA) : START;
            DATA:  state_n = (full_tick && bit_idx == 3'd7) ? STOP : DATA;
            STOP: begin
                byte_stb = full_tick & s2;
                ferr_n = full_tick & ~s2;
                state_n = full_tick ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
    end

    // Channel pressure/program change and MTC/song-select carry a single data byte.
    assign need1 = run_st[7:4] == 4'hC || run_st[7:4] == 4'hD || run_st == 8'hF1 || run_st == 8'hF3;

    always_comb begin
        run_n = run_st;
        sysex_n = sysex;
        d1_n = d1;
        idx_n = idx;
        emit = 1'b0;
        emit_msg = '0;
        emit_len = '0;
        if (byte_stb) begin
            if (shreg >= 8'hF8) begin
                emit = 1'b1;
                emit_msg = {shreg, 16'h0};
                emit_len = 2'd1;
            end else if (shreg[7]) begin
                sysex_n = shreg == 8'hF0;
                run_n = (shreg < 8'hF0 || shreg inside {8'hF1, 8'hF2, 8'hF3}) ? shreg : 8'h00;
                idx_n = 1'b0;
                emit = shreg == 8'hF6;
                emit_msg = {shreg, 16'h0};
                emit_len = 2'd1;
            end else if (run_st[7] && !sysex) begin
                if (!need1 && !idx) begin
                    d1_n = shreg;
                    idx_n = 1'b1;
                end else begin
                    emit = 1'b1;
                    emit_msg = need1 ? {run_st, shreg, 8'h00} : {run_st, d1, shreg};
                    emit_len = need1 ? 2'd2 : 2'd3;
                    idx_n = 1'b0;
                    run_n = run_st >= 8'hF0 ? 8'h00 : run_st;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_st <= '0;
            sysex <= 1'b0;
            d1 <= '0;
            idx <= 1'b0;
            msg_o <= '0;
            msg_len_o <= '0;
            msg_vld_o <= 1'b0;
            ovr_o <= 1'b0;
        end else begin
            run_st <= run_n;
            sysex <= sysex_n;
            d1 <= d1_n;
            idx <= idx_n;
            ovr_o <= emit && msg_vld_o && !msg_rdy_i;
            if (emit && (!msg_vld_o || msg_rdy_i)) begin
                msg_o <= emit_msg;
                msg_len_o <= emit_len;
                msg_vld_o <= 1'b1;
            end else if (msg_rdy_i) begin
                msg_vld_o <= 1'b0;
            end
        end
    end
endmodule
